// File: rtl/rr_arb4.sv
// Four-requester round-robin arbiter with registered one-hot grant and an optional hold timeout.
// The owner keeps the grant until it drops its request or the hold limit forces a release.
module rr_arb4 #(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_vld,
  output logic       timeout
);

  // state | meaning
  // IDLE  | no owner; next edge grants the first requester at or after ptr
  // GRANT | gnt_idx owns the resource; hold_cnt counts completed hold cycles
  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_t            state, state_n;
  logic [1:0]        ptr, ptr_n;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_n;
  logic [1:0]        idx_n;
  logic              vld_n;
  logic              timeout_n;
  logic [1:0]        pick_idx;
  logic              pick_vld;

  // Rotating scan starting at ptr; the first set request wins.
  always_comb begin
    pick_idx = ptr;
    pick_vld = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (req[ptr + 2'(i)]) begin
        pick_idx = ptr + 2'(i);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    hold_cnt_n = hold_cnt;
    idx_n      = gnt_idx;
    vld_n      = 1'b0;
    timeout_n  = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          idx_n      = pick_idx;
          vld_n      = 1'b1;
          hold_cnt_n = '0;
          state_n    = GRANT;
        end
      end
      GRANT: begin
        if (!req[gnt_idx]) begin
          ptr_n   = gnt_idx + 2'd1;
          state_n = IDLE;
        end else if (MAX_HOLD != 0 && hold_cnt == HOLD_LAST) begin
          timeout_n = 1'b1;
          ptr_n     = gnt_idx + 2'd1;
          state_n   = IDLE;
        end else begin
          vld_n = 1'b1;
          if (MAX_HOLD != 0) hold_cnt_n = hold_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt_idx  <= '0;
      gnt_vld  <= 1'b0;
      gnt      <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_cnt_n;
      gnt_idx  <= idx_n;
      gnt_vld  <= vld_n;
      gnt      <= vld_n ? (4'b0001 << idx_n) : 4'b0000;
      timeout  <= timeout_n;
    end
  end

endmodule

// File: tb/tb_rr_arb4.sv
// Directed vector bench for rr_arb4: table of per-edge stimulus and expected outputs,
// followed by a hand-written asynchronous reset sequence.
module tb_rr_arb4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_vld;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       vld;
    logic       to;
  } vec_t;

  vec_t vecs[$];

  rr_arb4 #(.MAX_HOLD(8), .HOLD_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input int n, input logic r, input logic [3:0] rq,
                     input logic [3:0] g, input logic [1:0] ix, input logic v, input logic t);
    vec_t e;
    e.rst = r; e.req = rq; e.gnt = g; e.idx = ix; e.vld = v; e.to = t;
    for (int k = 0; k < n; k++) vecs.push_back(e);
  endtask

  task automatic check(input string name, input logic [3:0] g, input logic [1:0] ix,
                       input logic v, input logic t);
    total++;
    if (gnt !== g || gnt_vld !== v || timeout !== t || (v && gnt_idx !== ix)) begin
      bad++;
      $display("FAIL %s: got gnt=%b idx=%0d vld=%b to=%b, want gnt=%b idx=%0d vld=%b to=%b",
               name, gnt, gnt_idx, gnt_vld, timeout, g, ix, v, t);
    end
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b1111;

    // reset held with all requests active
    add(3, 1, 4'b1111, 4'b0000, 2'd0, 0, 0);
    // single request, drop, then ptr=3 wins
    add(1, 0, 4'b0100, 4'b0100, 2'd2, 1, 0);
    add(1, 0, 4'b0000, 4'b0000, 2'd0, 0, 0);
    add(1, 0, 4'b1111, 4'b1000, 2'd3, 1, 0);
    add(1, 0, 4'b1111, 4'b1000, 2'd3, 1, 0);
    add(1, 0, 4'b0111, 4'b0000, 2'd0, 0, 0);
    // round robin 0,1,2,3,0 with one bubble between grants
    add(2, 0, 4'b1111, 4'b0001, 2'd0, 1, 0);
    add(1, 0, 4'b1110, 4'b0000, 2'd0, 0, 0);
    add(2, 0, 4'b1111, 4'b0010, 2'd1, 1, 0);
    add(1, 0, 4'b1101, 4'b0000, 2'd0, 0, 0);
    add(2, 0, 4'b1111, 4'b0100, 2'd2, 1, 0);
    add(1, 0, 4'b1011, 4'b0000, 2'd0, 0, 0);
    add(2, 0, 4'b1111, 4'b1000, 2'd3, 1, 0);
    add(1, 0, 4'b0111, 4'b0000, 2'd0, 0, 0);
    add(1, 0, 4'b1111, 4'b0001, 2'd0, 1, 0);
    // timeout: grant 0 lasts 8 cycles, then one-cycle pulse, next owner 1
    add(7, 0, 4'b0011, 4'b0001, 2'd0, 1, 0);
    add(1, 0, 4'b0011, 4'b0000, 2'd0, 0, 1);
    add(1, 0, 4'b0011, 4'b0010, 2'd1, 1, 0);
    add(1, 0, 4'b0001, 4'b0000, 2'd0, 0, 0);
    // lone requester 0 times out and is regranted after the bubble
    add(8, 0, 4'b0001, 4'b0001, 2'd0, 1, 0);
    add(1, 0, 4'b0001, 4'b0000, 2'd0, 0, 1);
    add(8, 0, 4'b0001, 4'b0001, 2'd0, 1, 0);
    // release on the same edge the hold limit is reached: no timeout
    add(1, 0, 4'b0000, 4'b0000, 2'd0, 0, 0);
    add(1, 0, 4'b0000, 4'b0000, 2'd0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst;
      req = vecs[i].req;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].idx, vecs[i].vld, vecs[i].to);
    end

    // async reset mid-grant (ptr is 1 after releasing owner 0)
    req = 4'b0010;
    @(posedge clk);
    #1;
    check("pre_rst_grant", 4'b0010, 2'd1, 1, 0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_clear", 4'b0000, 2'd0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    req = 4'b1111;
    @(posedge clk);
    #1;
    check("post_rst_grant", 4'b0001, 2'd0, 1, 0);
    req = 4'b0000;
    @(posedge clk);
    #1;
    check("post_rst_release", 4'b0000, 2'd0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_arb4.md
Name: rr_arb4

Overview:
- Four-requester round-robin arbiter that shares one resource slot between up to four requesters.
- Produces a one-hot grant vector through an internal 2-to-4 decode of the granted index.
- A grant is held until the owner drops its request or a hold timeout forces release.
- Sits between requesting agents and the shared datapath that the one-hot grant selects.

Parameters:
MAX_HOLD, 8, maximum consecutive cycles a grant may be held; 0 disables the timeout
HOLD_W, 4, hold counter width; MAX_HOLD must be <= 2^HOLD_W

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  reset, asynchronous, active-high
req  input  4  request lines; req[i] high means requester i wants the resource
gnt  output  4  one-hot grant; equals decode(gnt_idx) when gnt_vld=1, else 4'b0000
gnt_idx  output  2  index of the current owner, 0..3
gnt_vld  output  1  a grant is active
timeout  output  1  one-cycle pulse when a grant is force-released

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- While rst is high, with no clock edge required:
  - gnt=0000, gnt_idx=00, gnt_vld=0, timeout=0.
  - Priority pointer ptr=0, hold_cnt=0, state=IDLE.
- All outputs are registered.
- Decode mapping: idx 0->0001, 1->0010, 2->0100, 3->1000.
- State IDLE (gnt_vld=0):
  - At the edge, if req!=0, pick the first set req bit scanning ptr, ptr+1, ... mod 4.
  - That edge sets gnt_idx, gnt, gnt_vld=1, hold_cnt=0, and moves to GRANT.
  - Latency: request sampled at edge N produces the grant visible after edge N.
  - If req=0, remain in IDLE.
- State GRANT:
  - Release: req[gnt_idx]=0 at an edge clears gnt/gnt_vld at that edge, sets ptr=gnt_idx+1 mod 4, and goes to IDLE.
  - Timeout (MAX_HOLD!=0): req[gnt_idx]=1 with hold_cnt==MAX_HOLD-1 at an edge clears gnt/gnt_vld, sets timeout=1 for exactly one cycle, sets ptr=gnt_idx+1 mod 4, and goes to IDLE. The grant therefore lasts exactly MAX_HOLD cycles.
  - Otherwise hold_cnt increments and the grant is held. Other requests never preempt.
- Bubble: after any release or timeout, gnt_vld is low for exactly one cycle (the IDLE cycle) before the next grant.
- Simultaneous events:
  - Release and timeout condition at the same edge: release wins, timeout stays 0.
  - New requests arriving on the release edge are considered at the following IDLE edge with the updated ptr.
- Fairness: the requester just served gets the lowest priority. No requester waits more than 3 grants.
- gnt_idx keeps its last value in IDLE but is meaningful only when gnt_vld=1.
- Reset mid-grant: outputs and state clear immediately. timeout never asserts as a result of reset.
- MAX_HOLD=0: hold_cnt is ignored, timeout is never asserted, and a grant is held indefinitely.

Test Plan:
1. Reset: rst=1 with req=1111, clock running -> gnt=0000, gnt_vld=0, timeout=0 on every cycle.
2. Single request:
   - After reset, req=0100 -> gnt=0100 and gnt_idx=2 after the next edge.
   - Drop req -> gnt=0000 after the next edge.
   - Then req=1111 -> first grant is 1000 (ptr=3).
3. Round robin:
   - req=1111; each owner drops its req 2 cycles after grant and re-raises it 1 cycle later.
   - Grant order is 0001, 0010, 0100, 1000, 0001, with exactly one gnt_vld=0 cycle between grants.
4. Timeout (MAX_HOLD=8):
   - req=0011 held -> gnt=0001 for exactly 8 cycles, then timeout=1 for one cycle with gnt=0000.
   - Next grant is 0010.
   - With req=0001 only, the regrant after the bubble is 0001.
5. Release/timeout collision:
   - req[0] drops on the same edge where hold_cnt==7 -> gnt clears and timeout stays 0.
6. Async reset mid-grant:
   - While gnt=0010, pulse rst between clock edges -> gnt=0000 and gnt_vld=0 immediately.
   - After rst=0, req=1111 -> grant 0001.
